// File: rtl/pc_seq_pkg.sv
// Shared op encodings for the PC sequencer and its return stack.
package pc_seq_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD   = 3'b000;
    localparam logic [OP_W-1:0] OP_INC    = 3'b001;
    localparam logic [OP_W-1:0] OP_LOAD   = 3'b010;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'b011;
    localparam logic [OP_W-1:0] OP_CALL   = 3'b100;
    localparam logic [OP_W-1:0] OP_RET    = 3'b101;

endpackage

// File: rtl/pc_ret_stack.sv
// DEPTH x WIDTH LIFO holding return addresses; only the stack pointer is reset.
module pc_ret_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full  = (sp_q == SP_W'(DEPTH));
    assign empty = (sp_q == '0);

    // Reset wins over a coincident push or pop.
    assign do_push = push & ~full & ~reset;
    assign do_pop  = pop & ~empty & ~reset;

    assign wr_idx = sp_q[IDX_W-1:0];
    assign rd_idx = wr_idx - IDX_W'(1);

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (do_pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    assign dout = mem[rd_idx];
    assign sp   = sp_q;

endmodule

// File: rtl/pc_seq_stack.sv
// Fetch-stage PC sequencer with relative branch and call/return stack.
// Define PC_STKERR_STICKY_EN to make ovf/unf hold until reset.
module pc_seq_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      OFF_W     = 8,
    parameter int unsigned      DEPTH     = 8,
    parameter int unsigned      STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [OP_W-1:0]              op,
    input  logic [WIDTH-1:0]             d,
    input  logic [OFF_W-1:0]             off,
    output logic [WIDTH-1:0]             pc,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic                         unf
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_step;
    logic [WIDTH-1:0] pc_branch;
    logic [WIDTH-1:0] stk_dout;
    logic             stk_full;
    logic             stk_empty;
    logic             is_call;
    logic             is_ret;
    logic             push;
    logic             pop;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;

    assign pc_step   = pc_q + WIDTH'(STEP);
    // Size cast of a signed operand sign-extends the offset.
    assign pc_branch = pc_q + WIDTH'($signed(off));

    assign is_call = en & (op == OP_CALL);
    assign is_ret  = en & (op == OP_RET);
    assign push    = is_call & ~stk_full;
    assign pop     = is_ret & ~stk_empty;

    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_step),
        .dout  (stk_dout),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        pc_d = pc_q;
        if (en) begin
            case (op)
                OP_INC:    pc_d = pc_step;
                OP_LOAD:   pc_d = d;
                OP_BRANCH: pc_d = pc_branch;
                OP_CALL:   if (!stk_full) pc_d = d;
                OP_RET:    if (!stk_empty) pc_d = stk_dout;
                default:   pc_d = pc_q;
            endcase
        end
    end

    always_comb begin
`ifdef PC_STKERR_STICKY_EN
        ovf_d = ovf_q | (is_call & stk_full);
        unf_d = unf_q | (is_ret & stk_empty);
`else
        ovf_d = is_call & stk_full;
        unf_d = is_ret & stk_empty;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VAL;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc    = pc_q;
    assign full  = stk_full;
    assign empty = stk_empty;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule
